// File: rtl/fir_mac_datapath.sv
// Serial single-multiplier FIR datapath: coefficient store, sample delay line,
// one MAC per cycle over the active taps, Q1.15 saturated registered result.
module fir_mac_datapath #(
    parameter int MAX_TAPS = 16,
    parameter int ACC_W    = 40
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] tap_count,
    input  logic [31:0] coeff_data,
    input  logic        coeff_data_valid,
    input  logic [31:0] x_data,
    input  logic        x_data_valid,
    input  logic        compute,
    output logic        coefficient_loading_complete,
    output logic        output_data_valid,
    output logic [31:0] output_data,
    output logic        overrun
);
    localparam int IDX_W = $clog2(MAX_TAPS);
    localparam int CNT_W = IDX_W + 1;
    localparam int SH_W  = ACC_W - 15;
    localparam logic signed [SH_W-1:0] SAT_MAX = SH_W'(32767);
    localparam logic signed [SH_W-1:0] SAT_MIN = SH_W'(-32768);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        n_eff;
    logic [CNT_W-1:0]        wr_ptr_reg;
    logic                    complete_reg;
    logic signed [15:0]      coeff_tap [MAX_TAPS];
    logic signed [15:0]      delay_tap [MAX_TAPS];
    logic signed [ACC_W-1:0] acc_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic [31:0]             out_data_reg;
    logic                    out_valid_reg;
    logic                    overrun_reg;

    logic                    reload, coeff_wr, accept, mac_step, out_step, mac_last;
    logic signed [31:0]      product;
    logic signed [SH_W-1:0]  shifted;
    logic [15:0]             sat_val;
    logic                    unused_upper;

    assign unused_upper = ^{coeff_data[31:16], x_data[31:16]};

    always_comb begin
        if (tap_count == 32'd0)
            n_eff = CNT_W'(1);
        else if (tap_count > 32'(MAX_TAPS))
            n_eff = CNT_W'(MAX_TAPS);
        else
            n_eff = tap_count[CNT_W-1:0];
    end

    // ">=" rather than "==" so a tap count shrinking mid-MAC still terminates
    assign mac_last = ({1'b0, idx_reg} >= (n_eff - CNT_W'(1)));

    always_ff @(posedge clk) begin
        if (!rstn)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (x_data_valid && compute && complete_reg && !coeff_data_valid)
                      state_next = MAC;
            MAC:  if (!compute)
                      state_next = IDLE;
                  else if (mac_last)
                      state_next = OUT;
            OUT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        reload   = 1'b0;
        coeff_wr = 1'b0;
        accept   = 1'b0;
        mac_step = 1'b0;
        out_step = 1'b0;
        case (state_reg)
            IDLE: begin
                // a coefficient reload takes priority over a simultaneous sample
                reload   = coeff_data_valid && complete_reg;
                coeff_wr = coeff_data_valid && !complete_reg && (wr_ptr_reg < n_eff);
                accept   = x_data_valid && compute && complete_reg && !coeff_data_valid;
            end
            MAC:     mac_step = compute;
            OUT:     out_step = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_reg   <= '0;
            complete_reg <= 1'b0;
        end else if (reload) begin
            wr_ptr_reg   <= CNT_W'(1);
            complete_reg <= 1'b0;
        end else begin
            if (coeff_wr)
                wr_ptr_reg <= wr_ptr_reg + CNT_W'(1);
            complete_reg <= (wr_ptr_reg >= n_eff);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MAX_TAPS; gi++) begin : g_tap
            logic signed [15:0] coeff_reg;
            logic signed [15:0] delay_reg;
            logic               coeff_we;

            assign coeff_we = (reload && (gi == 0)) || (coeff_wr && (wr_ptr_reg == CNT_W'(gi)));

            always_ff @(posedge clk) begin
                if (!rstn)
                    coeff_reg <= '0;
                else if (coeff_we)
                    coeff_reg <= coeff_data[15:0];
            end

            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (!rstn || reload)
                        delay_reg <= '0;
                    else if (accept)
                        delay_reg <= x_data[15:0];
                end
            end else begin : g_shift
                always_ff @(posedge clk) begin
                    if (!rstn || reload)
                        delay_reg <= '0;
                    else if (accept)
                        delay_reg <= delay_tap[gi-1];
                end
            end

            assign coeff_tap[gi] = coeff_reg;
            assign delay_tap[gi] = delay_reg;
        end
    endgenerate

    assign product = coeff_tap[idx_reg] * delay_tap[idx_reg];

    always_ff @(posedge clk) begin
        if (!rstn || accept) begin
            acc_reg <= '0;
            idx_reg <= '0;
        end else if (mac_step) begin
            acc_reg <= acc_reg + {{(ACC_W-32){product[31]}}, product};
            idx_reg <= idx_reg + IDX_W'(1);
        end
    end

    assign shifted = acc_reg[ACC_W-1:15];

    always_comb begin
        if (shifted > SAT_MAX)
            sat_val = 16'h7FFF;
        else if (shifted < SAT_MIN)
            sat_val = 16'h8000;
        else
            sat_val = shifted[15:0];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            out_valid_reg <= out_step;
            if (out_step)
                out_data_reg <= {{16{sat_val[15]}}, sat_val};
            if (x_data_valid && (state_reg != IDLE))
                overrun_reg <= 1'b1;
        end
    end

    assign coefficient_loading_complete = complete_reg;
    assign output_data_valid            = out_valid_reg;
    assign output_data                  = out_data_reg;
    assign overrun                      = overrun_reg;
endmodule

// File: tb/tb_fir_mac_datapath.sv
// Self-checking bench for fir_mac_datapath: directed scenarios plus random
// coefficients/samples compared against an arithmetic FIR reference model.
module tb_fir_mac_datapath;
    localparam int MAX_TAPS = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] tap_count = '0;
    logic [31:0] coeff_data = '0;
    logic        coeff_data_valid = 1'b0;
    logic [31:0] x_data = '0;
    logic        x_data_valid = 1'b0;
    logic        compute = 1'b0;
    logic        complete;
    logic        output_data_valid;
    logic [31:0] output_data;
    logic        overrun;

    fir_mac_datapath #(.MAX_TAPS(MAX_TAPS), .ACC_W(40)) dut (
        .clk                          (clk),
        .rstn                         (rstn),
        .tap_count                    (tap_count),
        .coeff_data                   (coeff_data),
        .coeff_data_valid             (coeff_data_valid),
        .x_data                       (x_data),
        .x_data_valid                 (x_data_valid),
        .compute                      (compute),
        .coefficient_loading_complete (complete),
        .output_data_valid            (output_data_valid),
        .output_data                  (output_data),
        .overrun                      (overrun)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    int pulse_cnt = 0;

    // reference model state
    int                 m_n = 1;
    int                 m_wr = 0;
    bit                 m_complete = 1'b0;
    logic signed [15:0] m_coeff [MAX_TAPS];
    logic signed [15:0] m_delay [MAX_TAPS];

    always @(negedge clk)
        if (output_data_valid) pulse_cnt++;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic int eff_n(input logic [31:0] tc);
        if (tc == 32'd0) return 1;
        if (tc > 32'(MAX_TAPS)) return MAX_TAPS;
        return int'(tc);
    endfunction

    function automatic logic [31:0] sat16(input longint s);
        longint sh;
        sh = s >>> 15;
        if (sh > 32767) return 32'h0000_7FFF;
        if (sh < -32768) return 32'hFFFF_8000;
        return 32'(sh);
    endfunction

    task automatic model_reset();
        m_wr = 0;
        m_complete = 1'b0;
        m_n = eff_n(tap_count);
        for (int k = 0; k < MAX_TAPS; k++) begin
            m_coeff[k] = '0;
            m_delay[k] = '0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk_eq({tag, "_complete"}, 32'(complete), 32'd0);
        chk_eq({tag, "_valid"}, 32'(output_data_valid), 32'd0);
        chk_eq({tag, "_data"}, output_data, 32'd0);
        chk_eq({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    task automatic set_taps(input logic [31:0] tc);
        @(posedge clk); #1;
        tap_count = tc;
        m_n = eff_n(tc);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        m_complete = (m_wr >= m_n);
        chk_eq("complete_after_taps", 32'(complete), 32'(m_complete));
        $display("taps tap_count=%0d N=%0d complete=%0b", tc, m_n, complete);
    endtask

    // one coefficient strobe, optionally with a simultaneous sample strobe
    task automatic load_coeff(input logic [31:0] v, input bit with_x);
        int base;
        base = pulse_cnt;
        @(posedge clk); #1;
        coeff_data = v;
        coeff_data_valid = 1'b1;
        if (with_x) begin
            x_data = $urandom;
            x_data_valid = 1'b1;
            compute = 1'b1;
        end
        @(posedge clk); #1;
        coeff_data_valid = 1'b0;
        x_data_valid = 1'b0;
        coeff_data = $urandom;
        if (m_complete) begin
            m_coeff[0] = v[15:0];
            m_wr = 1;
            for (int k = 0; k < MAX_TAPS; k++) m_delay[k] = '0;
        end else if (m_wr < m_n) begin
            m_coeff[m_wr] = v[15:0];
            m_wr++;
        end
        @(posedge clk);
        @(negedge clk);
        m_complete = (m_wr >= m_n);
        chk_eq("complete_after_load", 32'(complete), 32'(m_complete));
        if (with_x) begin
            repeat (MAX_TAPS + 4) @(posedge clk);
            #2;
            chk_eq("coeff_x_no_result", 32'(pulse_cnt - base), 32'd0);
            chk_eq("coeff_x_no_overrun", 32'(overrun), 32'd0);
        end
        $display("coeff v=%04h wr=%0d complete=%0b", v[15:0], m_wr, complete);
    endtask

    function automatic logic [31:0] model_push(input logic [31:0] x);
        longint sum;
        for (int k = MAX_TAPS - 1; k > 0; k--) m_delay[k] = m_delay[k-1];
        m_delay[0] = x[15:0];
        sum = 0;
        for (int k = 0; k < m_n; k++)
            sum += longint'(m_coeff[k]) * longint'(m_delay[k]);
        return sat16(sum);
    endfunction

    task automatic send_sample(input logic [31:0] x, output logic [31:0] got);
        int          lat;
        logic [31:0] exp;
        exp = model_push(x);
        @(posedge clk); #1;
        x_data = x;
        x_data_valid = 1'b1;
        compute = 1'b1;
        @(posedge clk); #1;
        x_data_valid = 1'b0;
        x_data = $urandom;
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (output_data_valid) break;
        end
        chk_eq("latency", 32'(lat), 32'(m_n + 1));
        chk_eq("result", output_data, exp);
        got = output_data;
        @(negedge clk);
        chk_eq("pulse_width", 32'(output_data_valid), 32'd0);
        $display("sample x=%04h N=%0d lat=%0d out=%08h exp=%08h", x[15:0], m_n, lat, got, exp);
    endtask

    task automatic fill_coeffs_random();
        int guard;
        guard = 0;
        while (!m_complete && guard < 2 * MAX_TAPS + 4) begin
            load_coeff($urandom, 1'b0);
            guard++;
        end
        chk_eq("fill_complete", 32'(complete), 32'd1);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] exp;
        int          base;

        model_reset();
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check_all_zero("reset");

        // 3-tap basic load and filtering
        set_taps(32'd3);
        load_coeff(32'h0000_4000, 1'b0);
        load_coeff(32'hABCD_2000, 1'b0);
        load_coeff(32'h0000_2000, 1'b0);
        send_sample(32'h0000_4000, got);
        chk_eq("tp_first", got, 32'h0000_2000);
        send_sample(32'h1234_4000, got);
        chk_eq("tp_second", got, 32'h0000_3000);

        // positive saturation
        set_taps(32'd2);
        load_coeff(32'h0000_7FFF, 1'b0);
        load_coeff(32'h0000_7FFF, 1'b0);
        send_sample(32'h0000_7FFF, got);
        send_sample(32'h0000_7FFF, got);
        chk_eq("sat_pos", got, 32'h0000_7FFF);
        load_coeff(32'h0000_8000, 1'b0);
        load_coeff(32'h0000_8000, 1'b0);
        send_sample(32'h0000_8000, got);
        send_sample(32'h0000_8000, got);
        chk_eq("sat_negneg", got, 32'h0000_7FFF);

        // negative result and fractional truncation
        load_coeff(32'h0000_8000, 1'b0);
        load_coeff(32'h0000_7FFF, 1'b0);
        send_sample(32'h0000_4000, got);
        chk_eq("neg_result", got, 32'hFFFF_C000);
        send_sample(32'h0000_0000, got);
        chk_eq("trunc_result", got, 32'h0000_3FFF);

        // simultaneous coefficient and sample strobes with complete=1
        load_coeff(32'h0000_1234, 1'b1);
        load_coeff(32'h0000_4000, 1'b0);
        send_sample(32'h0000_2000, got);

        // overrun: second sample during MAC is dropped
        set_taps(32'd4);
        fill_coeffs_random();
        exp = model_push(32'h0000_3000);
        base = pulse_cnt;
        @(posedge clk); #1;
        x_data = 32'h0000_3000;
        x_data_valid = 1'b1;
        compute = 1'b1;
        @(posedge clk); #1;
        x_data_valid = 1'b0;
        @(posedge clk); #1;
        x_data = 32'h0000_7000;
        x_data_valid = 1'b1;
        @(posedge clk); #1;
        x_data_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        chk_eq("overrun_one_result", 32'(pulse_cnt - base), 32'd1);
        chk_eq("overrun_result", output_data, exp);
        chk_eq("overrun_flag", 32'(overrun), 32'd1);
        $display("overrun pulses=%0d out=%08h overrun=%0b", pulse_cnt - base, output_data, overrun);
        send_sample(32'h0000_1000, got);

        // compute dropped mid-MAC aborts without a result
        void'(model_push(32'h0000_2222));
        base = pulse_cnt;
        @(posedge clk); #1;
        x_data = 32'h0000_2222;
        x_data_valid = 1'b1;
        compute = 1'b1;
        @(posedge clk); #1;
        x_data_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        compute = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        chk_eq("abort_no_result", 32'(pulse_cnt - base), 32'd0);
        $display("abort pulses=%0d", pulse_cnt - base);
        send_sample(32'h0000_1111, got);

        // tap_count 0 clamps to one tap
        set_taps(32'd0);
        load_coeff(32'h0000_6000, 1'b0);
        chk_eq("n1_complete", 32'(complete), 32'd1);
        send_sample(32'h0000_5000, got);

        // tap_count above MAX_TAPS clamps to MAX_TAPS
        set_taps(32'd100);
        chk_eq("nmax_incomplete", 32'(complete), 32'd0);
        fill_coeffs_random();
        chk_eq("nmax_wr", 32'(m_wr), 32'(MAX_TAPS));
        for (int i = 0; i < 3; i++) send_sample($urandom, got);

        // randomized configurations
        for (int r = 0; r < 12; r++) begin
            set_taps(32'($urandom_range(0, MAX_TAPS + 4)));
            if (m_complete && ($urandom_range(0, 1) == 1))
                load_coeff($urandom, 1'b0);
            fill_coeffs_random();
            for (int i = 0; i < 3; i++) send_sample($urandom, got);
        end

        // reset in the middle of a MAC
        set_taps(32'd8);
        fill_coeffs_random();
        base = pulse_cnt;
        @(posedge clk); #1;
        x_data = $urandom;
        x_data_valid = 1'b1;
        compute = 1'b1;
        @(posedge clk); #1;
        x_data_valid = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("midmac_reset");
        #1 rstn = 1'b1;
        model_reset();
        repeat (16) @(posedge clk);
        #2;
        chk_eq("midmac_no_result", 32'(pulse_cnt - base), 32'd0);
        $display("midmac reset pulses=%0d", pulse_cnt - base);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fir_mac_datapath.md
Name: fir_mac_datapath

Overview:
- Filtering datapath that sits directly downstream of the FIR control unit and consumes its datapath-side outputs.
- Stores up to MAX_TAPS coefficients and keeps a sample delay line.
- For each accepted input sample, computes one output with a serial single-multiplier MAC over the active taps.
- Reports coefficient-load completion and a registered result with a one-cycle valid pulse.

Parameters:
MAX_TAPS, 16, maximum taps stored; power of two, 2..64
ACC_W, 40, accumulator width in bits; must be at least 32+clog2(MAX_TAPS)

Ports:
clk  input  1  clock
rstn  input  1  reset, synchronous, active-low
tap_count  input  32  requested tap count; clamped to give N (see Behaviour)
coeff_data  input  32  coefficient; bits [15:0] are signed Q1.15, upper bits ignored
coeff_data_valid  input  1  one-cycle strobe: write coeff_data at the current write pointer
x_data  input  32  input sample; bits [15:0] are signed Q1.15, upper bits ignored
x_data_valid  input  1  one-cycle strobe: new sample present
compute  input  1  level; enables sample acceptance and MAC
coefficient_loading_complete  output  1  level: N coefficients loaded
output_data_valid  output  1  one-cycle pulse: output_data has been updated
output_data  output  32  signed Q1.15 result, saturated to 16 bits, sign-extended to 32
overrun  output  1  sticky: a sample arrived while busy; cleared only by reset

Behaviour:
- Effective tap count N:
  - N = 1 if tap_count == 0.
  - N = MAX_TAPS if tap_count > MAX_TAPS.
  - Otherwise N = tap_count.
  - N is sampled combinationally and re-evaluated every cycle.
- Reset:
  - All outputs 0.
  - Coefficient array, delay line, write pointer, accumulator and MAC index all 0.
  - FSM goes to IDLE.
  - Reset mid-MAC aborts with no valid pulse.
- Coefficient load (accepted only in IDLE):
  - On coeff_data_valid: coeff[wr_ptr] <= coeff_data[15:0], then wr_ptr++.
  - When wr_ptr reaches N, coefficient_loading_complete goes high (registered) and wr_ptr stops advancing.
  - coeff_data_valid while complete=1 starts a new load: coeff[0] is written, wr_ptr=1, complete is cleared, and the delay line is cleared in the same edge.
  - coeff_data_valid in MAC or OUT state is dropped.
  - If N drops to or below wr_ptr while loading, complete asserts on the next edge.
- FSM states: IDLE, MAC, OUT.
  - IDLE -> MAC on an edge where x_data_valid & compute & complete. On that edge:
    - delay[0] <= x_data[15:0], delay[k] <= delay[k-1];
    - acc <= 0, idx <= 0.
  - x_data_valid in IDLE with compute=0 or complete=0 is ignored; nothing changes.
  - MAC: each cycle acc <= acc + sext(coeff[idx]*delay[idx]), using a 32-bit signed product. idx++.
  - MAC -> OUT after the edge that processes idx = N-1, i.e. exactly N MAC cycles.
  - MAC with compute=0 -> IDLE. No output; acc is discarded.
  - OUT: on the edge leaving OUT, output_data <= sat16(acc >>> 15) sign-extended; output_data_valid pulses high for the following cycle. Then -> IDLE.
  - Latency: sample accepted at edge E0; output_data and valid are visible after edge E0+N+1. Valid lasts one cycle.
  - output_data holds its value until the next result.
- Saturation:
  - Shifted value > 32767 gives 0x00007FFF.
  - Shifted value < -32768 gives 0xFFFF8000.
  - The accumulator itself never wraps for N ≤ MAX_TAPS.
- Overrun: x_data_valid in MAC or OUT sets overrun. That sample is dropped and the delay line is not shifted.
- Simultaneous x_data_valid and coeff_data_valid in IDLE:
  - With complete=1, the coefficient reload wins, the sample is dropped, and overrun is not set.
  - With complete=0, the coefficient write proceeds and the sample is ignored.
- Throughput: at most one sample per N+2 cycles.

Test Plan:
- Reset, then tap_count=3 and coeff writes 0x4000, 0x2000, 0x2000 -> complete=0 after the first two writes, complete=1 one cycle after the third.
- With the above loaded, compute=1, x=0x4000 -> output_data=0x00002000, valid pulse exactly 4 cycles after acceptance. Second x=0x4000 -> 0x00003000.
- tap_count=2, coeffs 0x7FFF, 0x7FFF, two samples 0x7FFF -> second output is 0x00007FFF (saturated). Coeffs 0x8000 with samples 0x8000 also give 0x00007FFF.
- With coeffs 0x8000, 0x7FFF, sample 0x4000 -> 0xFFFFC000; a second sample 0x0000 -> 0x00003FFF.
- x_data_valid pulsed twice 2 cycles apart with N=4 -> one result only, overrun=1, delay line shifted once.
- compute dropped mid-MAC -> no valid pulse, FSM in IDLE; tap_count=0 -> N=1, a single coeff write sets complete; tap_count=100 -> N=MAX_TAPS. Reset asserted mid-MAC -> all outputs 0 on the next cycle.
